// File: rtl/data_bank_array.sv
// -----------------------------------------------------------------------------
// data_bank_array
//
// Multi-bank coefficient memory for the NTT datapath. BANKS independent
// simple-dual-port banks of DEPTH x WIDTH, each with one write port and one
// registered read port, addressed in parallel by the butterfly address
// generator. A built-in clear engine zeroes every bank after reset or on
// request; while it runs all user traffic is ignored.
//
// Parameters
//   WIDTH  data word width in bits
//   DEPTH  words per bank (power of two, >= 2)
//   BANKS  number of independent banks (>= 1)
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset, priority over every other input
//   clr_req   request a full clear of all banks (honoured in RUN only)
//   wr_en     per-bank write enable
//   wr_addr   per-bank write address, bank b at [b*AW +: AW]
//   wr_data   per-bank write data,    bank b at [b*WIDTH +: WIDTH]
//   rd_en     per-bank read enable
//   rd_addr   per-bank read address,  bank b at [b*AW +: AW]
//   rd_data   per-bank registered read data
//   rd_valid  per-bank: rd_data was loaded by a read accepted last cycle
//   busy      clear engine active
// -----------------------------------------------------------------------------
module data_bank_array #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 128,
   parameter int BANKS = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr_req,
   input  logic [BANKS-1:0]       wr_en,
   input  logic [BANKS*AW-1:0]    wr_addr,
   input  logic [BANKS*WIDTH-1:0] wr_data,
   input  logic [BANKS-1:0]       rd_en,
   input  logic [BANKS*AW-1:0]    rd_addr,
   output logic [BANKS*WIDTH-1:0] rd_data,
   output logic [BANKS-1:0]       rd_valid,
   output logic                   busy
);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] cnt, cnt_nxt;

   // ---------------------------------------------------------------------------
   // Clear engine FSM
   // ---------------------------------------------------------------------------
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its inputs, independent of process ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         CLEAR: begin
            // cnt wraps to 0 on the last address, ready for the next clear.
            cnt_nxt = cnt + 1'b1;
            if (cnt == AW'(DEPTH - 1)) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (clr_req) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
         end
      endcase
   end

   // busy is a decode of the state register, so it carries no input-to-output
   // combinational path.
   assign busy = (state == CLEAR);

   // ---------------------------------------------------------------------------
   // Banks
   // ---------------------------------------------------------------------------
   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic [WIDTH-1:0] mem [DEPTH];

      logic [AW-1:0]    wa, ra;
      logic [WIDTH-1:0] wd;
      logic             mem_we;
      logic [AW-1:0]    mem_addr;
      logic [WIDTH-1:0] mem_din;
      logic [WIDTH-1:0] rd_q;
      logic             vld_q;

      assign wa = wr_addr[b*AW +: AW];
      assign ra = rd_addr[b*AW +: AW];
      assign wd = wr_data[b*WIDTH +: WIDTH];

      // Single write port shared by the clear engine and the user. The clear
      // engine owns it whenever busy; reset blocks all writes.
      always_comb begin
         mem_we   = 1'b0;
         mem_addr = wa;
         mem_din  = wd;
         if (!rst_n) begin
            mem_we = 1'b0;
         end else if (busy) begin
            mem_we   = 1'b1;
            mem_addr = cnt;
            mem_din  = '0;
         end else begin
            mem_we = wr_en[b];
         end
      end

      // NOTE: the array itself has no reset so it maps onto RAM macros; its
      // contents are defined only by the clear engine.
      always_ff @(posedge clk) begin
         if (mem_we) begin
            mem[mem_addr] <= mem_din;
         end
      end

      // Registered read port. A same-address write in the same cycle is
      // forwarded so the reader sees the new word (write-first).
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            rd_q  <= '0;
            vld_q <= 1'b0;
         end else if (busy) begin
            vld_q <= 1'b0;
         end else if (rd_en[b]) begin
            vld_q <= 1'b1;
            rd_q  <= (wr_en[b] && (wa == ra)) ? wd : mem[ra];
         end else begin
            vld_q <= 1'b0;
         end
      end

      assign rd_data[b*WIDTH +: WIDTH] = rd_q;
      assign rd_valid[b]               = vld_q;
   end

endmodule

// File: tb/tb_data_bank_array.sv
// -----------------------------------------------------------------------------
// tb_data_bank_array
//
// Bench for data_bank_array. Instance u_dut uses the default geometry
// (12 x 128 x 4); u_dut2 uses WIDTH=16, DEPTH=32, BANKS=8. Single-cycle bank
// behaviour is checked from a vector table; clear timing, busy blocking and
// reset-during-clear are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_data_bank_array;

   localparam int W  = 12;
   localparam int D  = 128;
   localparam int B  = 4;
   localparam int AW = 7;

   localparam int W2  = 16;
   localparam int D2  = 32;
   localparam int B2  = 8;
   localparam int AW2 = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default instance
   logic             rst_n, clr_req, busy;
   logic [B-1:0]     wr_en, rd_en, rd_valid;
   logic [B*AW-1:0]  wr_addr, rd_addr;
   logic [B*W-1:0]   wr_data, rd_data;

   // small instance
   logic              rst2_n, clr2_req, busy2;
   logic [B2-1:0]     wr2_en, rd2_en, rd2_valid;
   logic [B2*AW2-1:0] wr2_addr, rd2_addr;
   logic [B2*W2-1:0]  wr2_data, rd2_data;

   data_bank_array u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_req  (clr_req),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .busy     (busy)
   );

   data_bank_array #(.WIDTH(W2), .DEPTH(D2), .BANKS(B2)) u_dut2 (
      .clk      (clk),
      .rst_n    (rst2_n),
      .clr_req  (clr2_req),
      .wr_en    (wr2_en),
      .wr_addr  (wr2_addr),
      .wr_data  (wr2_data),
      .rd_en    (rd2_en),
      .rd_addr  (rd2_addr),
      .rd_data  (rd2_data),
      .rd_valid (rd2_valid),
      .busy     (busy2)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle0();
      clr_req = 1'b0;
      wr_en   = '0;
      wr_addr = '0;
      wr_data = '0;
      rd_en   = '0;
      rd_addr = '0;
   endtask

   task automatic idle1();
      clr2_req = 1'b0;
      wr2_en   = '0;
      wr2_addr = '0;
      wr2_data = '0;
      rd2_en   = '0;
      rd2_addr = '0;
   endtask

   // Counts edges until busy drops (bounded). Also counts cycles on which
   // rd_valid was not 0 or rd_data moved away from hold. Optionally pulses
   // clr_req on the 50th clearing edge.
   task automatic wait_clear0(input bit pulse, input logic [B*W-1:0] hold,
                              output int n, output int bad);
      n   = 0;
      bad = 0;
      for (int i = 1; i <= 4 * D; i++) begin
         clr_req = (pulse && i == 50);
         cycle();
         n = i;
         if (rd_valid !== '0 || rd_data !== hold) bad++;
         if (busy === 1'b0) break;
      end
      clr_req = 1'b0;
   endtask

   task automatic wait_clear1(output int n);
      n = 0;
      for (int i = 1; i <= 4 * D2; i++) begin
         cycle();
         n = i;
         if (busy2 === 1'b0) break;
      end
   endtask

   // Reads every address of all banks; each must return 0 with rd_valid set.
   task automatic read_sweep0(input string tag);
      idle0();
      for (int a = 0; a < D; a++) begin
         rd_en   = '1;
         rd_addr = {B{AW'(a)}};
         cycle();
         check($sformatf("%s_a%0d", tag, a), 128'({rd_valid, rd_data}),
               128'({4'hF, 48'h0}));
      end
      idle0();
   endtask

   typedef struct {
      int             bank;
      bit             we;
      bit [AW-1:0]    wa;
      bit [W-1:0]     wd;
      bit             re;
      bit [AW-1:0]    ra;
      bit [W-1:0]     exp_d;
      bit [B-1:0]     exp_v;
   } vec_t;

   vec_t vec [13];

   initial begin
      int n, bad;
      logic [B*W-1:0] held;

      // bank, we, wa, wd, re, ra, expected slice, expected rd_valid
      vec[0]  = '{2, 1'b1, 7'd5,   12'hABC, 1'b0, 7'd0,   12'h000, 4'b0000};
      vec[1]  = '{2, 1'b0, 7'd0,   12'h000, 1'b1, 7'd5,   12'hABC, 4'b0100};
      vec[2]  = '{0, 1'b1, 7'd7,   12'h456, 1'b0, 7'd0,   12'h000, 4'b0000};
      vec[3]  = '{0, 1'b1, 7'd7,   12'h123, 1'b1, 7'd7,   12'h123, 4'b0001};
      vec[4]  = '{0, 1'b0, 7'd0,   12'h000, 1'b1, 7'd7,   12'h123, 4'b0001};
      vec[5]  = '{1, 1'b1, 7'd3,   12'h0F0, 1'b0, 7'd0,   12'h000, 4'b0000};
      vec[6]  = '{1, 1'b0, 7'd0,   12'h000, 1'b1, 7'd3,   12'h0F0, 4'b0010};
      vec[7]  = '{1, 1'b0, 7'd0,   12'h000, 1'b0, 7'd0,   12'h0F0, 4'b0000};
      vec[8]  = '{3, 1'b1, 7'd127, 12'hFFF, 1'b1, 7'd127, 12'hFFF, 4'b1000};
      vec[9]  = '{3, 1'b1, 7'd0,   12'h001, 1'b1, 7'd127, 12'hFFF, 4'b1000};
      vec[10] = '{3, 1'b0, 7'd0,   12'h000, 1'b1, 7'd0,   12'h001, 4'b1000};
      vec[11] = '{2, 1'b1, 7'd5,   12'h555, 1'b1, 7'd4,   12'h000, 4'b0100};
      vec[12] = '{2, 1'b0, 7'd0,   12'h000, 1'b1, 7'd5,   12'h555, 4'b0100};

      idle0();
      idle1();
      rst_n  = 1'b0;
      rst2_n = 1'b0;
      cycle();
      cycle();
      check("reset_busy",  128'(busy),     128'(1));
      check("reset_valid", 128'(rd_valid), 128'(0));
      check("reset_data",  128'(rd_data),  128'(0));

      // Release reset while hammering writes/reads; all must be ignored.
      rst_n   = 1'b1;
      wr_en   = '1;
      wr_addr = '0;
      wr_data = '1;
      rd_en   = '1;
      rd_addr = '0;
      wait_clear0(1'b0, '0, n, bad);
      check("init_clear_cycles", 128'(n), 128'(D));
      check("init_busy_ignored", 128'(bad), 128'(0));
      idle0();
      read_sweep0("init_sweep");

      // Single-cycle bank behaviour.
      foreach (vec[i]) begin
         idle0();
         wr_en[vec[i].bank]                 = vec[i].we;
         wr_addr[vec[i].bank*AW +: AW]      = vec[i].wa;
         wr_data[vec[i].bank*W +: W]        = vec[i].wd;
         rd_en[vec[i].bank]                 = vec[i].re;
         rd_addr[vec[i].bank*AW +: AW]      = vec[i].ra;
         cycle();
         check($sformatf("vec%0d_data", i), 128'(rd_data[vec[i].bank*W +: W]), 128'(vec[i].exp_d));
         check($sformatf("vec%0d_valid", i), 128'(rd_valid), 128'(vec[i].exp_v));
      end
      idle0();

      // Fill every bank with nonzero data.
      for (int a = 0; a < D; a++) begin
         wr_en = '1;
         for (int b = 0; b < B; b++) begin
            wr_addr[b*AW +: AW] = AW'(a);
            wr_data[b*W +: W]   = W'(a + 1 + b * 256);
         end
         cycle();
      end
      idle0();
      rd_en   = '1;
      rd_addr = {B{7'd10}};
      cycle();
      check("fill_read_data",  128'(rd_data),  128'({12'h30B, 12'h20B, 12'h10B, 12'h00B}));
      check("fill_read_valid", 128'(rd_valid), 128'(4'hF));

      // clr_req cycle: the same-cycle read of bank 1 addr 20 is still serviced.
      idle0();
      clr_req              = 1'b1;
      wr_en                = 4'b0001;
      wr_addr[0 +: AW]     = 7'd20;
      wr_data[0 +: W]      = 12'h999;
      rd_en                = 4'b0010;
      rd_addr[AW +: AW]    = 7'd20;
      cycle();
      held = {12'h30B, 12'h20B, 12'h115, 12'h00B};
      check("clr_req_data",  128'(rd_data),  128'(held));
      check("clr_req_valid", 128'(rd_valid), 128'(4'b0010));
      check("clr_req_busy",  128'(busy),     128'(1));

      // During the clear: traffic ignored, repeated clr_req does not extend it.
      clr_req = 1'b0;
      wr_en   = '1;
      wr_addr = '0;
      wr_data = '1;
      rd_en   = '1;
      rd_addr = {B{7'd0}};
      wait_clear0(1'b1, held, n, bad);
      check("req_clear_cycles", 128'(n), 128'(D));
      check("req_busy_ignored", 128'(bad), 128'(0));
      idle0();
      read_sweep0("req_sweep");

      // Reset pulse at cnt=60 restarts a full clear.
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 60; i++) cycle();
      check("mid_clear_busy", 128'(busy), 128'(1));
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      wait_clear0(1'b0, '0, n, bad);
      check("rst_mid_clear_cycles", 128'(n), 128'(D));

      // Small geometry instance.
      rst2_n = 1'b1;
      wait_clear1(n);
      check("p2_clear_cycles", 128'(n), 128'(D2));
      rst2_n = 1'b0;
      cycle();
      rst2_n = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      rst2_n = 1'b0;
      cycle();
      rst2_n = 1'b1;
      wait_clear1(n);
      check("p2_rst_mid_clear_cycles", 128'(n), 128'(D2));

      idle1();
      wr2_en                    = 8'h80;
      wr2_addr[7*AW2 +: AW2]    = 5'd31;
      wr2_data[7*W2 +: W2]      = 16'hBEEF;
      cycle();
      idle1();
      rd2_en                    = 8'hA0;
      rd2_addr[7*AW2 +: AW2]    = 5'd31;
      wr2_en                    = 8'h20;
      wr2_addr[5*AW2 +: AW2]    = 5'd0;
      wr2_data[5*W2 +: W2]      = 16'h1234;
      rd2_addr[5*AW2 +: AW2]    = 5'd0;
      cycle();
      check("p2_bank7_data",  128'(rd2_data[7*W2 +: W2]), 128'(16'hBEEF));
      check("p2_bank5_fwd",   128'(rd2_data[5*W2 +: W2]), 128'(16'h1234));
      check("p2_bank0_data",  128'(rd2_data[0 +: W2]),    128'(0));
      check("p2_valid",       128'(rd2_valid),            128'(8'hA0));
      idle1();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/data_bank_array.md
# data_bank_array

Parametrised multi-bank coefficient memory for the NTT datapath: BANKS independent simple-dual-port banks (one write port, one read port each) of DEPTH x WIDTH, addressed in parallel by the butterfly address generator. Generalises the single 128 x 12 bank with per-bank valid tracking, write-first forwarding on same-address collisions, and a built-in clear engine that zeroes every bank after reset or on request. Sits between the address/control unit and the butterfly array.

## Interface
- WIDTH, 12, data word width in bits
- DEPTH, 128, words per bank (power of two, >= 2); AW = clog2(DEPTH)
- BANKS, 4, number of independent banks (>= 1)
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- clr_req  input  1  request a full clear of all banks (sampled in RUN only)
- wr_en  input  BANKS  per-bank write enable
- wr_addr  input  BANKS*AW  per-bank write address, bank b at bits [b*AW +: AW]
- wr_data  input  BANKS*WIDTH  per-bank write data, bank b at [b*WIDTH +: WIDTH]
- rd_en  input  BANKS  per-bank read enable
- rd_addr  input  BANKS*AW  per-bank read address
- rd_data  output  BANKS*WIDTH  per-bank registered read data
- rd_valid  output  BANKS  per-bank: rd_data updated by a read accepted last cycle
- busy  output  1  clear engine active; all user requests ignored

## Operation
- FSM states: CLEAR, RUN. Clear counter cnt (AW bits).
- Reset (rst_n=0 at an edge): state<=CLEAR, cnt<=0, rd_data<=0, rd_valid<=0, busy<=1. Memory arrays are not reset directly; contents defined only by the clear engine.
- CLEAR: every cycle write 0 to address cnt in all banks; cnt<=cnt+1. When cnt==DEPTH-1: state<=RUN, busy<=0. wr_en/rd_en ignored; rd_valid forced 0; rd_data holds. clr_req ignored (no restart).
- RUN, clr_req=1: state<=CLEAR, cnt<=0, busy<=1; user requests on that same cycle are still serviced normally.
- RUN, per bank b: wr_en[b]=1 writes wr_data slice to wr_addr slice. rd_en[b]=1 loads rd_data slice from rd_addr slice and sets rd_valid[b]=1; rd_en[b]=0 holds rd_data slice, clears rd_valid[b].
- Collision (same bank, wr_en=rd_en=1, wr_addr==rd_addr): write-first; rd_data returns the new wr_data, not the stored word.
- Banks fully independent; no cross-bank forwarding or arbitration.
- rst_n has priority over every other input; reset mid-CLEAR or mid-RUN restarts the clear from address 0.

## Timing
- Read latency 1 cycle: address at edge N, data and rd_valid visible after edge N (usable at edge N+1).
- Write visible to a read issued the same cycle (forwarding) or any later cycle.
- Clear duration: exactly DEPTH cycles; busy high from reset through the edge writing address DEPTH-1, low after it; first accepted user request at edge DEPTH+1 counted from first edge with rst_n=1.
- clr_req in RUN: busy rises after that edge; banks writable again DEPTH cycles later.
- No combinational path from inputs to outputs.

## Test plan
- Reset release, default params: busy=1 for exactly 128 cycles, then 0; read every address of all 4 banks -> rd_data=0, rd_valid=1 one cycle after each read.
- Bank 2 write 12'hABC to addr 5, next cycle read addr 5 -> rd_data[35:24]=12'hABC, rd_valid=4'b0100; other slices unchanged.
- Same-cycle bank 0 write 12'h123 and read, both addr 7 (old content 12'h456) -> rd_data[11:0]=12'h123.
- rd_en low after a read of 12'h0F0 -> rd_data holds 12'h0F0, rd_valid returns 0; writes/reads issued while busy=1 -> memory and rd_data unchanged.
- Fill all banks with nonzero data, pulse clr_req -> busy for 128 cycles, subsequent reads all 0; clr_req pulses during CLEAR do not extend busy.
- rst_n low for one cycle at cnt=60 of a clear -> cnt restarts, busy lasts a full 128 cycles from release; repeat with WIDTH=16, DEPTH=32, BANKS=8.
